// File: rtl/irrigation_timer_pkg.sv
`default_nettype none
// ============================================================================
// irrigation_timer_pkg : shared state encoding, digit limits, BCD load check
// Revision: 1.0
// ============================================================================
package irrigation_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SEC_U_MAX = 9;
    localparam int SEC_D_MAX = 5;
    localparam int MIN_U_MAX = 9;
    localparam int MIN_D_MAX = 3;

    // min_d needs no check: its 2-bit field cannot exceed MIN_D_MAX
    function automatic logic bcd_valid(input logic [3:0] min_u,
                                       input logic [2:0] sec_d,
                                       input logic [3:0] sec_u);
        return (min_u <= 4'(MIN_U_MAX)) && (sec_d <= 3'(SEC_D_MAX)) &&
               (sec_u <= 4'(SEC_U_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_countdown_timer_digit.sv
`default_nettype none
// ============================================================================
// bcd_down_digit : one loadable down-counting digit that wraps 0 -> MAX
// Revision: 1.0
// ============================================================================
module bcd_down_digit
    import irrigation_timer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] digit,
    output logic             is_zero,
    output logic             borrow_out
);

    logic [WIDTH-1:0] r_digit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= load_val;
        end else if (dec_en) begin
            r_digit <= (r_digit == '0) ? WIDTH'(MAX) : r_digit - 1'b1;
        end
    end

    assign digit      = r_digit;
    assign is_zero    = (r_digit == '0);
    assign borrow_out = dec_en & is_zero;

endmodule
`default_nettype wire

// File: rtl/irrigation_countdown_timer.sv
`default_nettype none
// ============================================================================
// irrigation_countdown_timer : BCD mm:ss countdown with preset/default load
// Revision: 1.0
// ============================================================================
module irrigation_countdown_timer
    import irrigation_timer_pkg::*;
#(
    parameter bit TICK_ACTIVE   = 1'b1,
    parameter int DEFAULT_MIN_D = 0,
    parameter int DEFAULT_MIN_U = 5,
    parameter int DEFAULT_SEC_D = 0,
    parameter int DEFAULT_SEC_U = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       enable,
    input  logic       load,
    input  logic       load_default,
    input  logic [1:0] preset_min_d,
    input  logic [3:0] preset_min_u,
    input  logic [2:0] preset_sec_d,
    input  logic [3:0] preset_sec_u,
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic       running,
    output logic       expired,
    output logic       conflicting_values
);

    state_t     r_state, w_state_next;
    logic       r_expired, r_conflict;
    logic       w_load_any, w_load_valid, w_load_zero, w_tick, w_dec, w_at_one;
    logic [1:0] w_sel_min_d, w_ld_min_d;
    logic [3:0] w_sel_min_u, w_ld_min_u, w_sel_sec_u, w_ld_sec_u;
    logic [2:0] w_sel_sec_d, w_ld_sec_d;
    logic       w_borrow_su, w_borrow_sd, w_borrow_mu, w_borrow_md;
    logic       w_zero_su, w_zero_sd, w_zero_mu, w_zero_md;
    logic       w_unused;

    // explicit preset beats the parameter defaults
    assign w_load_any  = load | load_default;
    assign w_sel_min_d = load ? preset_min_d : 2'(DEFAULT_MIN_D);
    assign w_sel_min_u = load ? preset_min_u : 4'(DEFAULT_MIN_U);
    assign w_sel_sec_d = load ? preset_sec_d : 3'(DEFAULT_SEC_D);
    assign w_sel_sec_u = load ? preset_sec_u : 4'(DEFAULT_SEC_U);

    assign w_load_valid = bcd_valid(w_sel_min_u, w_sel_sec_d, w_sel_sec_u);
    assign w_load_zero  = ({w_sel_min_d, w_sel_min_u, w_sel_sec_d, w_sel_sec_u} == '0);
    assign w_ld_min_d   = w_load_valid ? w_sel_min_d : '0;
    assign w_ld_min_u   = w_load_valid ? w_sel_min_u : '0;
    assign w_ld_sec_d   = w_load_valid ? w_sel_sec_d : '0;
    assign w_ld_sec_u   = w_load_valid ? w_sel_sec_u : '0;

    // a load in the same cycle swallows the tick
    assign w_tick   = (tick_1hz == TICK_ACTIVE);
    assign w_dec    = (r_state == RUN) & enable & w_tick & ~w_load_any;
    assign w_at_one = w_zero_md & w_zero_mu & w_zero_sd & (seconds_u == 4'd1);

    bcd_down_digit #(.WIDTH(4), .MAX(SEC_U_MAX)) u_sec_u (
        .clock(clock), .reset(reset), .dec_en(w_dec), .load(w_load_any),
        .load_val(w_ld_sec_u), .digit(seconds_u), .is_zero(w_zero_su),
        .borrow_out(w_borrow_su)
    );
    bcd_down_digit #(.WIDTH(3), .MAX(SEC_D_MAX)) u_sec_d (
        .clock(clock), .reset(reset), .dec_en(w_borrow_su), .load(w_load_any),
        .load_val(w_ld_sec_d), .digit(seconds_d), .is_zero(w_zero_sd),
        .borrow_out(w_borrow_sd)
    );
    bcd_down_digit #(.WIDTH(4), .MAX(MIN_U_MAX)) u_min_u (
        .clock(clock), .reset(reset), .dec_en(w_borrow_sd), .load(w_load_any),
        .load_val(w_ld_min_u), .digit(minutes_u), .is_zero(w_zero_mu),
        .borrow_out(w_borrow_mu)
    );
    bcd_down_digit #(.WIDTH(2), .MAX(MIN_D_MAX)) u_min_d (
        .clock(clock), .reset(reset), .dec_en(w_borrow_mu), .load(w_load_any),
        .load_val(w_ld_min_d), .digit(minutes_d), .is_zero(w_zero_md),
        .borrow_out(w_borrow_md)
    );

    // RUN never holds 00:00, so the top digit can never borrow
    assign w_unused = &{1'b0, w_borrow_md, w_zero_su};

    always_comb begin
        w_state_next = r_state;
        if (w_load_any) begin
            w_state_next = (!w_load_valid || w_load_zero) ? IDLE : ARMED;
        end else begin
            case (r_state)
                ARMED: if (enable) w_state_next = RUN;
                RUN: begin
                    if (!enable)                w_state_next = ARMED;
                    else if (w_tick && w_at_one) w_state_next = DONE;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_expired  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_expired <= (r_state == RUN) && (w_state_next == DONE);
            if (w_load_any) r_conflict <= ~w_load_valid;
        end
    end

    assign running            = (r_state == RUN);
    assign expired            = r_expired;
    assign conflicting_values = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_countdown_timer.sv
`default_nettype none
// ============================================================================
// tb_irrigation_countdown_timer : directed + random bench vs seconds-based model
// Revision: 1.0
// ============================================================================
module tb_irrigation_countdown_timer;

    logic       clock = 1'b0;
    logic       reset, tick_1hz, enable, load, load_default;
    logic [1:0] preset_min_d;
    logic [3:0] preset_min_u, preset_sec_u;
    logic [2:0] preset_sec_d;
    logic [1:0] minutes_d;
    logic [3:0] minutes_u, seconds_u;
    logic [2:0] seconds_d;
    logic       running, expired, conflicting_values;
    logic [12:0] dut_val;

    int checks   = 0;
    int failures = 0;

    // model: value as plain seconds, mode 0 idle / 1 armed / 2 run / 3 done
    int m_secs = 0;
    int m_mode = 0;
    bit m_conf = 1'b0;
    bit m_exp  = 1'b0;

    irrigation_countdown_timer dut (
        .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .enable(enable),
        .load(load), .load_default(load_default),
        .preset_min_d(preset_min_d), .preset_min_u(preset_min_u),
        .preset_sec_d(preset_sec_d), .preset_sec_u(preset_sec_u),
        .minutes_d(minutes_d), .minutes_u(minutes_u),
        .seconds_d(seconds_d), .seconds_u(seconds_u),
        .running(running), .expired(expired),
        .conflicting_values(conflicting_values)
    );

    always #5 clock = ~clock;

    assign dut_val = {minutes_d, minutes_u, seconds_d, seconds_u};

    function automatic logic [12:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {2'(m / 10), 4'(m % 10), 3'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic model_step();
        int md, mu, sd, su;
        m_exp = 1'b0;
        if (reset) begin
            m_secs = 0; m_mode = 0; m_conf = 1'b0;
        end else if (load || load_default) begin
            if (load) begin
                md = preset_min_d; mu = preset_min_u; sd = preset_sec_d; su = preset_sec_u;
            end else begin
                md = 0; mu = 5; sd = 0; su = 0;
            end
            if (mu <= 9 && sd <= 5 && su <= 9) begin
                m_secs = (md * 10 + mu) * 60 + sd * 10 + su;
                m_conf = 1'b0;
                m_mode = (m_secs == 0) ? 0 : 1;
            end else begin
                m_secs = 0; m_conf = 1'b1; m_mode = 0;
            end
        end else if (m_mode == 1) begin
            if (enable) m_mode = 2;
        end else if (m_mode == 2) begin
            if (!enable) m_mode = 1;
            else if (tick_1hz) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_mode = 3; m_exp = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (dut_val === to_bcd(m_secs)) else begin
            failures++;
            $error("FAIL %s digits got=%h exp=%h", tag, dut_val, to_bcd(m_secs));
        end
        checks++;
        assert (running === (m_mode == 2)) else begin
            failures++;
            $error("FAIL %s running got=%b exp=%b", tag, running, (m_mode == 2));
        end
        checks++;
        assert (expired === m_exp) else begin
            failures++;
            $error("FAIL %s expired got=%b exp=%b", tag, expired, m_exp);
        end
        checks++;
        assert (conflicting_values === m_conf) else begin
            failures++;
            $error("FAIL %s conflict got=%b exp=%b", tag, conflicting_values, m_conf);
        end
    endtask

    task automatic expect_val(input string tag, input logic [12:0] exp);
        checks++;
        assert (dut_val === exp) else begin
            failures++;
            $error("FAIL %s digits got=%h exp=%h", tag, dut_val, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic set_preset(input int md, input int mu, input int sd, input int su);
        preset_min_d = 2'(md); preset_min_u = 4'(mu);
        preset_sec_d = 3'(sd); preset_sec_u = 4'(su);
    endtask

    task automatic pulse_load(input string tag);
        load = 1'b1; cycle(tag); load = 1'b0;
    endtask

    task automatic pulse_tick(input string tag);
        tick_1hz = 1'b1; cycle(tag); tick_1hz = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; enable = 1'b0; load = 1'b0; load_default = 1'b0;
        set_preset(0, 0, 0, 0);
        cycle("reset0");
        cycle("reset1");
        reset = 1'b0;

        // countdown to expiry, extra tick must not underflow
        set_preset(0, 0, 0, 3);
        pulse_load("t1_load");
        enable = 1'b1;
        cycle("t1_arm");
        for (int i = 0; i < 4; i++) begin
            pulse_tick("t1_tick");
            cycle("t1_gap");
        end
        expect_val("t1_done", 13'h0);

        // full borrow chain
        set_preset(1, 0, 0, 0);
        pulse_load("t2_load");
        cycle("t2_arm");
        pulse_tick("t2_borrow");
        expect_val("t2_0959", {2'd0, 4'd9, 3'd5, 4'd9});
        for (int i = 0; i < 60; i++) pulse_tick("t2_tick");
        expect_val("t2_0859", {2'd0, 4'd8, 3'd5, 4'd9});

        // invalid then valid load
        set_preset(0, 12, 0, 0);
        pulse_load("t3_bad");
        cycle("t3_idle");
        set_preset(0, 1, 0, 0);
        pulse_load("t3_good");

        // pause keeps value
        set_preset(0, 0, 3, 0);
        pulse_load("t4_load");
        cycle("t4_arm");
        enable = 1'b0;
        cycle("t4_pause");
        for (int i = 0; i < 5; i++) pulse_tick("t4_held");
        expect_val("t4_0030", {2'd0, 4'd0, 3'd3, 4'd0});
        enable = 1'b1;
        cycle("t4_rearm");
        pulse_tick("t4_tick");
        expect_val("t4_0029", {2'd0, 4'd0, 3'd2, 4'd9});

        // load wins over tick; preset wins over default
        set_preset(0, 0, 1, 0);
        pulse_load("t5_load10");
        cycle("t5_arm");
        set_preset(0, 0, 2, 0);
        tick_1hz = 1'b1; load = 1'b1;
        cycle("t5_load_tick");
        tick_1hz = 1'b0; load = 1'b0;
        expect_val("t5_0020", {2'd0, 4'd0, 3'd2, 4'd0});
        set_preset(0, 0, 4, 5);
        load = 1'b1; load_default = 1'b1;
        cycle("t5_both");
        load = 1'b0;
        cycle("t5_default_only");
        load_default = 1'b0;
        expect_val("t5_default", {2'd0, 4'd5, 3'd0, 4'd0});

        // reset mid-run
        set_preset(0, 5, 0, 8);
        pulse_load("t6_load");
        cycle("t6_arm");
        pulse_tick("t6_0507");
        reset = 1'b1; tick_1hz = 1'b1;
        cycle("t6_reset");
        reset = 1'b0; tick_1hz = 1'b0;
        cycle("t6_after");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 59) == 0);
            load         = ($urandom_range(0, 19) == 0);
            load_default = ($urandom_range(0, 39) == 0);
            tick_1hz     = ($urandom_range(0, 2) == 0);
            enable       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                set_preset(0, 0, $urandom_range(0, 1), $urandom_range(0, 15));
            else
                set_preset($urandom_range(0, 3), $urandom_range(0, 15),
                           $urandom_range(0, 7), $urandom_range(0, 15));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
